// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants and types for the scanline sprite scheduler: attribute
// word layout, bitmap row geometry and the scheduler state encoding.
package sprite_pkg;

    localparam int ATTR_W   = 28;
    localparam int EN_BIT   = 27;
    localparam int TILE_LSB = 23;
    localparam int TILE_FW  = 4;
    localparam int Y_LSB    = 12;
    localparam int Y_W      = 11;
    localparam int X_LSB    = 0;
    localparam int X_W      = 12;

    localparam int ROW_BITS = 3;
    localparam int SPR_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Attribute-table and bitmap-memory read ports shared between the scheduler
// (master) and the memories that answer one cycle after each address.
interface sprite_line_scheduler_if #(
    parameter int NUM_SPRITES = 16,
    parameter int TILE_W      = 4
);
    import sprite_pkg::*;

    logic [$clog2(NUM_SPRITES)-1:0] attrAddr;
    logic [ATTR_W-1:0]              attrData;
    logic [TILE_W+ROW_BITS-1:0]     bmapAddr;
    logic [SPR_W-1:0]               bmapData;

    modport master (output attrAddr, output bmapAddr, input attrData, input bmapData);
    modport slave  (input attrAddr, input bmapAddr, output attrData, output bmapData);

endinterface

// File: rtl/sprite_line_scheduler_slot_unit.sv
// One committed sprite slot: holds x, bitmap row and valid for the current
// line and reports whether the pixel at i_hpix is set for this sprite.
module sprite_slot_unit
    import sprite_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_commit,
    input  logic                  i_valid,
    input  logic signed [X_W-1:0] i_x,
    input  logic [SPR_W-1:0]      i_bits,
    input  logic signed [X_W-1:0] i_hpix,
    output logic                  o_hit
);

    logic                  r_valid;
    logic signed [X_W-1:0] r_x;
    logic [SPR_W-1:0]      r_bits;
    logic [X_W-1:0]        w_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_valid <= 1'b0;
        else if (i_commit) r_valid <= i_valid;
    end

    // Payload needs no reset; r_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (i_commit) begin
            r_x    <= i_x;
            r_bits <= i_bits;
        end
    end

    assign w_d   = i_hpix - r_x;
    assign o_hit = r_valid && (w_d[X_W-1:ROW_BITS] == '0) && r_bits[3'd7 - w_d[ROW_BITS-1:0]];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute table for the line two
// ahead, fetches one bitmap row per picked sprite, commits at lineStart.
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES  = 16,
    parameter int MAX_PER_LINE = 4,
    parameter int TILE_W       = 4
) (
    input  logic                     crystalCLK,
    input  logic                     reset,
    input  logic signed [11:0]       horizontalPix,
    input  logic signed [10:0]       verticalPix,
    input  logic                     lineStart,
    sprite_line_scheduler_if.master  mem,
    output logic                     pixelOn,
    output logic [2:0]               pixelSlot,
    output logic                     busy,
    output logic                     lineOverflow,
    output logic                     lateError
);

    localparam int AW = $clog2(NUM_SPRITES);
    localparam int CW = $clog2(NUM_SPRITES + MAX_PER_LINE + 1);
    localparam int SW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic signed [Y_W-1:0] r_target;
    logic [3:0]            r_used;
    logic                  r_shOvf;

    logic signed [X_W-1:0] r_shX    [MAX_PER_LINE];
    logic [TILE_W-1:0]     r_shTile [MAX_PER_LINE];
    logic [ROW_BITS-1:0]   r_shRow  [MAX_PER_LINE];
    logic [SPR_W-1:0]      r_shBits [MAX_PER_LINE];

    logic                  w_late, w_eval, w_hit, w_full, w_store, w_cap;
    logic                  w_scanLast, w_fetchLast;
    logic signed [Y_W-1:0] w_y;
    logic [X_W-1:0]        w_dy;
    logic [CW-1:0]         w_cntM1;
    logic [SW-1:0]         w_storeIdx, w_capIdx, w_fetchIdx;
    logic [MAX_PER_LINE-1:0] w_slotHit;

    assign busy        = (r_state == SCAN) || (r_state == FETCH);
    assign w_late      = lineStart && busy;
    assign w_scanLast  = (r_state == SCAN)  && (r_cnt == CW'(NUM_SPRITES));
    assign w_fetchLast = (r_state == FETCH) && (8'(r_cnt) == 8'(r_used));

    // Attribute entry returned this cycle belongs to address r_cnt-1.
    assign w_eval  = (r_state == SCAN) && (r_cnt != '0);
    assign w_y     = mem.attrData[Y_LSB +: Y_W];
    assign w_dy    = {r_target[Y_W-1], r_target} - {w_y[Y_W-1], w_y};
    assign w_hit   = w_eval && mem.attrData[EN_BIT] && (w_dy[X_W-1:ROW_BITS] == '0);
    assign w_full  = (r_used == 4'(MAX_PER_LINE));
    assign w_store = w_hit && !w_full;
    assign w_cap   = (r_state == FETCH) && (r_cnt != '0);

    assign w_cntM1    = r_cnt - 1'b1;
    assign w_storeIdx = r_used[SW-1:0];
    assign w_capIdx   = w_cntM1[SW-1:0];
    assign w_fetchIdx = r_cnt[SW-1:0];

    assign mem.attrAddr = ((r_state == SCAN) && (r_cnt < CW'(NUM_SPRITES))) ? r_cnt[AW-1:0] : '0;
    assign mem.bmapAddr = ((r_state == FETCH) && (8'(r_cnt) < 8'(r_used)))
                        ? {r_shTile[w_fetchIdx], r_shRow[w_fetchIdx]} : '0;

    always_comb begin
        w_next = r_state;
        if (lineStart) begin
            w_next = SCAN;
        end else begin
            case (r_state)
                SCAN:    if (w_scanLast) w_next = ((r_used != '0) || w_store) ? FETCH : DONE;
                FETCH:   if (w_fetchLast) w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge crystalCLK or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge crystalCLK or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_target     <= '0;
            r_used       <= '0;
            r_shOvf      <= 1'b0;
            lineOverflow <= 1'b0;
            lateError    <= 1'b0;
        end else if (lineStart) begin
            r_cnt        <= '0;
            r_target     <= verticalPix + 11'sd2;
            r_used       <= '0;
            r_shOvf      <= 1'b0;
            lineOverflow <= w_late ? 1'b0 : r_shOvf;
            if (w_late) lateError <= 1'b1;
        end else begin
            if (w_scanLast || w_fetchLast) r_cnt <= '0;
            else if (busy)                 r_cnt <= r_cnt + 1'b1;
            if (w_store)          r_used  <= r_used + 1'b1;
            if (w_hit && w_full)  r_shOvf <= 1'b1;
        end
    end

    always_ff @(posedge crystalCLK) begin
        if (w_store) begin
            r_shX[w_storeIdx]    <= mem.attrData[X_LSB +: X_W];
            r_shTile[w_storeIdx] <= mem.attrData[TILE_LSB +: TILE_W];
            r_shRow[w_storeIdx]  <= w_dy[ROW_BITS-1:0];
        end
        if (w_cap) r_shBits[w_capIdx] <= mem.bmapData;
    end

    for (genvar s = 0; s < MAX_PER_LINE; s++) begin : g_slot
        sprite_slot_unit u_slot (
            .clk     (crystalCLK),
            .rst     (reset),
            .i_commit(lineStart),
            .i_valid (!w_late && (4'(s) < r_used)),
            .i_x     (r_shX[s]),
            .i_bits  (r_shBits[s]),
            .i_hpix  (horizontalPix),
            .o_hit   (w_slotHit[s])
        );
    end

    logic       w_on;
    logic [2:0] w_slot;

    always_comb begin
        w_on   = 1'b0;
        w_slot = 3'd0;
        for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
            if (w_slotHit[s]) begin
                w_on   = 1'b1;
                w_slot = 3'(s);
            end
        end
    end

    always_ff @(posedge crystalCLK or posedge reset) begin
        if (reset) begin
            pixelOn   <= 1'b0;
            pixelSlot <= 3'd0;
        end else begin
            pixelOn   <= w_on;
            pixelSlot <= w_slot;
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed and randomized bench for sprite_line_scheduler with a table-driven
// reference model of scan, fetch, commit and pixel priority.
module tb_sprite_line_scheduler;
    import sprite_pkg::*;

    localparam int N    = 16;
    localparam int MAXP = 4;
    localparam int TW   = 4;

    logic               crystalCLK = 1'b0;
    logic               reset = 1'b0;
    logic signed [11:0] horizontalPix = '0;
    logic signed [10:0] verticalPix = '0;
    logic               lineStart = 1'b0;
    logic               pixelOn, busy, lineOverflow, lateError;
    logic [2:0]         pixelSlot;

    sprite_line_scheduler_if #(.NUM_SPRITES(N), .TILE_W(TW)) m ();

    sprite_line_scheduler #(.NUM_SPRITES(N), .MAX_PER_LINE(MAXP), .TILE_W(TW)) dut (
        .crystalCLK   (crystalCLK),
        .reset        (reset),
        .horizontalPix(horizontalPix),
        .verticalPix  (verticalPix),
        .lineStart    (lineStart),
        .mem          (m),
        .pixelOn      (pixelOn),
        .pixelSlot    (pixelSlot),
        .busy         (busy),
        .lineOverflow (lineOverflow),
        .lateError    (lateError)
    );

    always #5 crystalCLK = ~crystalCLK;

    logic [27:0] attr_tbl [N];
    logic [7:0]  bmap_tbl [128];

    always @(posedge crystalCLK) begin
        m.attrData <= attr_tbl[m.attrAddr];
        m.bmapData <= bmap_tbl[m.bmapAddr];
    end

    logic [6:0] fq[$];
    always @(negedge crystalCLK) if (busy && m.bmapAddr != 7'd0) fq.push_back(m.bmapAddr);

    int n_cmp = 0;
    int n_fail = 0;

    int         sh_used = 0, act_used = 0;
    int         sh_x [8], act_x [8];
    logic [7:0] sh_bits [8], act_bits [8];
    bit         sh_ovf = 0, act_ovf = 0, exp_late = 0;
    int         last_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] mk(input int en, input int tile, input int y, input int x);
        return {en[0], 4'(tile), 11'(y), 12'(x)};
    endfunction

    task automatic model_scan(input int v);
        int target, hits, yi, xi, dy;
        logic signed [10:0] y;
        logic signed [11:0] x;
        target = v + 2;
        hits = 0;
        sh_used = 0;
        for (int i = 0; i < N; i++) begin
            y = attr_tbl[i][22:12];
            x = attr_tbl[i][11:0];
            yi = y;
            xi = x;
            dy = target - yi;
            if (attr_tbl[i][27] && dy >= 0 && dy <= 7) begin
                hits++;
                if (sh_used < MAXP) begin
                    sh_x[sh_used]    = xi;
                    sh_bits[sh_used] = bmap_tbl[{attr_tbl[i][26:23], dy[2:0]}];
                    sh_used++;
                end
            end
        end
        sh_ovf = (hits > MAXP);
    endtask

    task automatic model_pix(input int h, output bit on, output int slot);
        int d;
        on = 0;
        slot = 0;
        for (int s = 0; s < act_used; s++) begin
            d = h - act_x[s];
            if (!on && d >= 0 && d <= 7 && act_bits[s][7-d]) begin
                on = 1;
                slot = s;
            end
        end
    endtask

    task automatic line_start(input int v, input bit late);
        if (late) begin
            act_used = 0;
            act_ovf  = 0;
            exp_late = 1;
        end else begin
            act_used = sh_used;
            act_x    = sh_x;
            act_bits = sh_bits;
            act_ovf  = sh_ovf;
        end
        model_scan(v);
        fq.delete();
        verticalPix = 11'(v);
        lineStart = 1'b1;
        @(posedge crystalCLK);
        #1;
        lineStart = 1'b0;
        check("lineOverflow", 32'(lineOverflow), 32'(act_ovf));
        check("lateError", 32'(lateError), 32'(exp_late));
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (busy && cnt < 200) begin
            @(posedge crystalCLK);
            #1;
            cnt++;
        end
        last_busy = cnt;
        check("busy_cycles", cnt, N + 1 + ((sh_used > 0) ? sh_used + 1 : 0));
    endtask

    task automatic line(input int v);
        line_start(v, 1'b0);
        wait_idle();
    endtask

    task automatic check_pix(input int h);
        bit on;
        int slot;
        horizontalPix = 12'(h);
        @(posedge crystalCLK);
        #1;
        model_pix(h, on, slot);
        check("pixelOn", 32'(pixelOn), 32'(on));
        check("pixelSlot", 32'(pixelSlot), slot);
    endtask

    task automatic check_pix_exp(input int h, input bit on, input int slot);
        horizontalPix = 12'(h);
        @(posedge crystalCLK);
        #1;
        check("pixelOn_dir", 32'(pixelOn), 32'(on));
        check("pixelSlot_dir", 32'(pixelSlot), slot);
    endtask

    task automatic sweep(input int a, input int b);
        for (int h = a; h <= b; h++) check_pix(h);
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < N; i++) attr_tbl[i] = mk(0, 0, 500, 0);
    endtask

    task automatic load_overlap_tbl();
        clear_tbl();
        attr_tbl[0] = mk(1, 1, 32, 200);
        attr_tbl[1] = mk(1, 3, 30, 40);
        attr_tbl[2] = mk(1, 1, 31, 300);
        attr_tbl[3] = mk(1, 4, 29, 40);
        bmap_tbl[{4'd3, 3'd2}] = 8'hFF;
        bmap_tbl[{4'd4, 3'd3}] = 8'hFF;
    endtask

    int v, tgt;

    initial begin
        for (int b = 0; b < 128; b++) bmap_tbl[b] = 8'($urandom);
        clear_tbl();
        #1 reset = 1'b1;
        #1;
        check("rst_pixelOn", 32'(pixelOn), 0);
        check("rst_pixelSlot", 32'(pixelSlot), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_lineOverflow", 32'(lineOverflow), 0);
        check("rst_lateError", 32'(lateError), 0);
        check("rst_attrAddr", 32'(m.attrAddr), 0);
        check("rst_bmapAddr", 32'(m.bmapAddr), 0);
        @(posedge crystalCLK);
        @(posedge crystalCLK);
        #1 reset = 1'b0;

        // Single sprite, edge pixels of an 8'b1000_0001 row
        attr_tbl[0] = mk(1, 2, 10, 100);
        bmap_tbl[{4'd2, 3'd0}] = 8'b1000_0001;
        line(8);
        check("t1_fetch_n", fq.size(), 1);
        check("t1_fetch_addr", (fq.size() > 0) ? 32'(fq[0]) : 32'hFFFF, 32'h10);
        line(8);
        check_pix_exp(99, 0, 0);
        check_pix_exp(100, 1, 0);
        check_pix_exp(101, 0, 0);
        check_pix_exp(104, 0, 0);
        check_pix_exp(107, 1, 0);
        check_pix_exp(108, 0, 0);
        sweep(90, 115);

        // Six hits for four slots
        clear_tbl();
        for (int i = 0; i < 6; i++) attr_tbl[i] = mk(1, i + 1, 22 - i, 10 * i);
        attr_tbl[6] = mk(0, 7, 22, 5);
        line(20);
        check("t2_busy", last_busy, N + 1 + 4 + 1);
        line(20);
        check("t2_ovf", 32'(lineOverflow), 1);
        sweep(0, 60);

        // Overlapping slots 1 and 3: lower slot wins
        load_overlap_tbl();
        line(30);
        line(30);
        check_pix_exp(39, 0, 0);
        for (int h = 40; h < 48; h++) check_pix_exp(h, 1, 1);
        check_pix_exp(48, 0, 0);
        sweep(36, 50);

        // Negative x and y
        clear_tbl();
        attr_tbl[0] = mk(1, 5, -3, -4);
        bmap_tbl[{4'd5, 3'd2}] = 8'hF5;
        line(-3);
        check("t4_fetch_n", fq.size(), 1);
        check("t4_fetch_addr", (fq.size() > 0) ? 32'(fq[0]) : 32'hFFFF, 32'h2A);
        line(-3);
        check_pix_exp(0, 0, 0);
        check_pix_exp(1, 1, 0);
        check_pix_exp(2, 0, 0);
        check_pix_exp(3, 1, 0);
        check_pix_exp(4, 0, 0);
        sweep(0, 12);

        // lineStart arriving mid-scan
        line_start(-3, 1'b0);
        repeat (4) @(posedge crystalCLK);
        #1;
        line_start(-3, 1'b1);
        check("t5_late", 32'(lateError), 1);
        check("t5_ovf", 32'(lineOverflow), 0);
        wait_idle();
        check_pix_exp(1, 0, 0);
        sweep(0, 6);
        line(-3);
        check_pix_exp(1, 1, 0);
        check_pix_exp(3, 1, 0);

        // Reset during FETCH
        load_overlap_tbl();
        line(30);
        horizontalPix = 12'sd43;
        line_start(30, 1'b0);
        repeat (N + 1) @(posedge crystalCLK);
        #1;
        check("t6_pre_busy", 32'(busy), 1);
        check("t6_pre_on", 32'(pixelOn), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_pixelOn", 32'(pixelOn), 0);
        check("t6_pixelSlot", 32'(pixelSlot), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_lineOverflow", 32'(lineOverflow), 0);
        check("t6_lateError", 32'(lateError), 0);
        check("t6_attrAddr", 32'(m.attrAddr), 0);
        check("t6_bmapAddr", 32'(m.bmapAddr), 0);
        @(posedge crystalCLK);
        #1 reset = 1'b0;
        sh_used = 0;
        sh_ovf = 0;
        act_used = 0;
        act_ovf = 0;
        exp_late = 0;
        line(30);
        check_pix_exp(43, 0, 0);
        sweep(38, 50);
        line(30);
        check_pix_exp(43, 1, 1);

        // Randomized lines against the model
        for (int it = 0; it < 12; it++) begin
            v = $urandom_range(0, 400);
            tgt = v + 2;
            for (int b = 0; b < 128; b++) bmap_tbl[b] = 8'($urandom);
            for (int i = 0; i < N; i++)
                attr_tbl[i] = mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                                 tgt + 2 - int'($urandom_range(0, 11)),
                                 int'($urandom_range(0, 80)) - 10);
            line(v);
            sweep(-12, 72);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
